// File: rtl/multi_pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: mode encoding and
// channel-index width helper.
package multi_pulse_gen_pkg;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // Channel index needs at least one bit even for a single channel.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multi_pulse_gen_pulse_channel.sv
// One pulse channel: counter, run flag, shadow/active period and mode, pulse compare.
// Shadow values move to active only at a wrap, on a start, or while idle.
module multi_pulse_gen_pulse_channel
   import multi_pulse_gen_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned DEFAULT_PERIOD = 10_000_000,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             we,
   input  logic [WIDTH-1:0] wr_period,
   input  logic             wr_oneshot,
   input  logic             start,
   input  logic             stop,
   output logic             pulse,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO      = '0;
   localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] act_period_q, act_period_d;
   logic [WIDTH-1:0] shd_period_q, shd_period_d;
   logic             act_mode_q, act_mode_d;
   logic             shd_mode_q, shd_mode_d;
   logic             running_q, running_d;
   logic             at_last;

   // A running channel never holds act_period 0, so the wrapped compare is safe.
   assign at_last = (cnt_q == (act_period_q - ONE));
   assign pulse   = running_q & ce & at_last;
   assign busy    = running_q;

   always_comb begin
      // Shadow as it will be after this edge; a start or wrap sees same-cycle writes.
      shd_period_d = we ? wr_period  : shd_period_q;
      shd_mode_d   = we ? wr_oneshot : shd_mode_q;

      cnt_d        = cnt_q;
      running_d    = running_q;
      act_period_d = act_period_q;
      act_mode_d   = act_mode_q;

      if (!running_q) begin
         act_period_d = shd_period_d;
         act_mode_d   = shd_mode_d;
      end

      if (stop) begin
         running_d = 1'b0;
         cnt_d     = ZERO;
      end else if (start) begin
         act_period_d = shd_period_d;
         act_mode_d   = shd_mode_d;
         cnt_d        = ZERO;
         running_d    = (shd_period_d != ZERO);
      end else if (!running_q) begin
         cnt_d = ZERO;
      end else if (ce) begin
         if (at_last) begin
            cnt_d        = ZERO;
            act_period_d = shd_period_d;
            act_mode_d   = shd_mode_d;
            // One-shot ends here; a pending period of 0 acts as a stop.
            if ((act_mode_q == MODE_ONESHOT) || (shd_period_d == ZERO)) begin
               running_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= ZERO;
         act_period_q <= RST_PERIOD;
         shd_period_q <= RST_PERIOD;
         act_mode_q   <= MODE_PERIODIC;
         shd_mode_q   <= MODE_PERIODIC;
         running_q    <= AUTO_START;
      end else begin
         cnt_q        <= cnt_d;
         act_period_q <= act_period_d;
         shd_period_q <= shd_period_d;
         act_mode_q   <= act_mode_d;
         shd_mode_q   <= shd_mode_d;
         running_q    <= running_d;
      end
   end

endmodule

// File: rtl/multi_pulse_gen.sv
// N-channel programmable periodic/one-shot pulse generator with shared count enable.
// Decodes the config channel address and replicates one pulse channel per output.
module multi_pulse_gen
   import multi_pulse_gen_pkg::*;
#(
   parameter int unsigned NCH            = 4,
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned DEFAULT_PERIOD = 10_000_000,
   parameter bit          AUTO_START     = 1'b1,
   localparam int unsigned CH_W          = ch_width(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic             cfg_oneshot,
   input  logic [NCH-1:0]   start,
   input  logic [NCH-1:0]   stop,
   output logic [NCH-1:0]   pulse,
   output logic [NCH-1:0]   busy
);

   logic [NCH-1:0] ch_we;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      // Addresses at or above NCH match no channel and are dropped.
      assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

      multi_pulse_gen_pulse_channel #(
         .WIDTH          (WIDTH),
         .DEFAULT_PERIOD (DEFAULT_PERIOD),
         .AUTO_START     (AUTO_START)
      ) u_channel (
         .clk        (clk),
         .rst        (rst),
         .ce         (ce),
         .we         (ch_we[i]),
         .wr_period  (cfg_period),
         .wr_oneshot (cfg_oneshot),
         .start      (start[i]),
         .stop       (stop[i]),
         .pulse      (pulse[i]),
         .busy       (busy[i])
      );
   end

endmodule
